ws_tile_sched: RTL and testbench
================================

WS_TILE_SCHED -- requirements
Module: ws_tile_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): M, 4, array rows; N, 4, array cols; K, 128, activation vector length per tile.
REQ-002 SHALL have parameters TW, 8, tile-index width; WDOG_SLACK, 8, extra watchdog cycles.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  job request.
REQ-006 cmd_ready  out  1  scheduler can accept a job.
REQ-007 cmd_rows  in  TW  row-tile count of the job.
REQ-008 cmd_cols  in  TW  col-tile count of the job.
REQ-009 abort  in  1  terminate current job.
REQ-010 arr_start_load  out  1  one-cycle pulse starting the array's weight-load phase.
REQ-011 arr_start_compute  out  1  one-cycle pulse starting the activation stream.
REQ-012 arr_done  in  1  array tile-complete pulse.
REQ-013 tile_row, tile_col  out  TW each  index of the current tile.
REQ-014 wb_valid  out  1  tile result ready for writeback; wb_ready  in  1  writeback accepted.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky); tiles_done  out  2*TW.

Function
REQ-016 SHALL implement states IDLE, ISSUE, LOADW, COMP, WB, NEXT, FIN.
REQ-017 cmd_ready SHALL equal (state==IDLE); a job SHALL be accepted on cmd_valid&&cmd_ready, latching cmd_rows/cmd_cols, clearing tiles_done, tile_row, tile_col and err.
REQ-018 An accepted job with cmd_rows==0 or cmd_cols==0 SHALL go directly to FIN (no array pulses; tiles_done=0).
REQ-019 ISSUE SHALL last one cycle, assert arr_start_load for that cycle, then enter LOADW.
REQ-020 LOADW SHALL count M*N cycles, then assert arr_start_compute for exactly one cycle and enter COMP.
REQ-021 COMP SHALL wait for arr_done, then enter WB; arr_done in any other state SHALL be ignored.
REQ-022 WB SHALL hold wb_valid=1 with stable tile_row/tile_col until wb_ready; on handshake, increment tiles_done and enter NEXT.
REQ-023 NEXT SHALL advance tile_col; at cmd_cols-1 it SHALL wrap to 0 and increment tile_row; after tile (cmd_rows-1, cmd_cols-1) it SHALL enter FIN, else ISSUE.
REQ-024 Traversal order SHALL be row-major: (0,0),(0,1)...(0,C-1),(1,0)...; total tiles = cmd_rows*cmd_cols.
REQ-025 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Watchdog: a counter started at ISSUE SHALL, if arr_done has not arrived within M*N+K+WDOG_SLACK cycles, set err=1 and enter FIN.
REQ-028 abort in any non-IDLE state SHALL set err=1 and force FIN next cycle; abort in WB SHALL drop wb_valid without counting the tile; abort in IDLE SHALL be ignored.
REQ-029 abort coincident with wb_ready in WB SHALL take priority (tile not counted).
REQ-030 err SHALL remain set until the next job is accepted.

Reset
REQ-031 On rst_n low, SHALL asynchronously enter IDLE with cmd_ready=1 and all other outputs 0 (tile_row, tile_col, tiles_done, err, busy, done, wb_valid, arr_start_*).
REQ-032 Reset mid-job SHALL abandon the job without done pulse; the first edge after release SHALL be able to accept a job.

Structure
REQ-033 State enum and tile-index type SHALL reside in a shared package ws_pkg, also used by the array.
REQ-034 The watchdog SHALL be a sub-module ws_wdog (start, clear, limit, expired); everything else SHALL be inline.

Verification
REQ-035 rows=2, cols=3, array model (arr_done K cycles after arr_start_compute), wb_ready=1 -> six tiles (0,0)..(1,2) row-major, tiles_done=6, single done, err=0.
REQ-036 Single tile -> arr_start_compute exactly 16 cycles after arr_start_load (M=N=4), wb_valid one cycle after arr_done.
REQ-037 wb_ready held low 5 cycles -> wb_valid and indices stable for 5 cycles, no next arr_start_load until handshake.
REQ-038 arr_done never asserted -> err=1 and done exactly 152 cycles after arr_start_load (16+128+8), then cmd_ready=1.
REQ-039 abort during COMP of tile 2 of 4 -> done next cycle, err=1, tiles_done=1; cmd_rows=0 -> done with no array pulses.
REQ-040 rst_n asserted in LOADW -> all outputs reset immediately, no done; new job after release runs normally.

Source files
------------

// File: rtl/ws_pkg.sv
// Shared types for the weight-stationary tile scheduler and the systolic array.
package ws_pkg;

  // Default tile-index width shared with the array
  localparam int WS_TW  = 8;
  // Watchdog counter width; comfortably covers M*N+K+slack for realistic arrays
  localparam int WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOADW,
    ST_COMP,
    ST_WB,
    ST_NEXT,
    ST_FIN
  } ws_state_e;

  typedef logic [WS_TW-1:0] tile_idx_t;

  // Cycles allowed from ISSUE until the array reports a finished tile
  function automatic logic [WDOG_W-1:0] wdog_limit(input int m, input int n,
                                                   input int k, input int slack);
    return WDOG_W'(m * n + k + slack);
  endfunction

endpackage

// File: rtl/ws_tile_sched_if.sv
// Job-command, array-control and writeback signals of the tile scheduler.
interface ws_tile_sched_if #(
  parameter int TW = 8
);
  import ws_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [TW-1:0]     cmd_rows;
  logic [TW-1:0]     cmd_cols;
  logic              abort;
  logic              arr_start_load;
  logic              arr_start_compute;
  logic              arr_done;
  logic [TW-1:0]     tile_row;
  logic [TW-1:0]     tile_col;
  logic              wb_valid;
  logic              wb_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [2*TW-1:0]   tiles_done;

  // Scheduler side
  modport slave (
    input  cmd_valid, cmd_rows, cmd_cols, abort, arr_done, wb_ready,
    output cmd_ready, arr_start_load, arr_start_compute, tile_row, tile_col,
           wb_valid, busy, done, err, tiles_done
  );

  // Host / array side
  modport master (
    output cmd_valid, cmd_rows, cmd_cols, abort, arr_done, wb_ready,
    input  cmd_ready, arr_start_load, arr_start_compute, tile_row, tile_col,
           wb_valid, busy, done, err, tiles_done
  );

endinterface

// File: rtl/ws_wdog.sv
// Tile watchdog: armed by start, disarmed by clear, flags when a tile overruns.
module ws_wdog
  import ws_pkg::*;
#(
  parameter int W = WDOG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic         armed_q, armed_d;
  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of cycles elapsed since the start cycle, so the
  // flag rises in the last allowed cycle and the owner leaves on the next edge
  assign expired = armed_q && (cnt_q >= (limit - W'(1)));

  // Next-state: clear beats start so an abort in the start cycle disarms
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (clear) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (start) begin
      armed_d = 1'b1;
      cnt_d   = W'(1);
    end else if (armed_q && !expired) begin
      cnt_d   = cnt_q + W'(1);
    end
  end

  // Counter and arm flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ws_tile_sched.sv
// Weight-stationary tile scheduler: walks a rows x cols job in row-major order,
// sequencing weight load, compute and writeback for each tile.
module ws_tile_sched
  import ws_pkg::*;
#(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 128,
  parameter int TW         = 8,
  parameter int WDOG_SLACK = 8
) (
  input logic            clk,
  input logic            rst_n,
  ws_tile_sched_if.slave bus
);

  localparam int               LOAD_CYC = M * N;
  localparam int               LCW      = $clog2(LOAD_CYC) + 1;
  localparam logic [LCW-1:0]   LD_LAST  = LCW'(LOAD_CYC - 1);
  localparam logic [TW-1:0]    IDX_ONE  = TW'(1);
  localparam logic [2*TW-1:0]  CNT_ONE  = (2*TW)'(1);
  localparam logic [WDOG_W-1:0] WD_LIMIT = wdog_limit(M, N, K, WDOG_SLACK);

  ws_state_e         state_q, state_d;
  logic [TW-1:0]     rows_q, rows_d;
  logic [TW-1:0]     cols_q, cols_d;
  logic [TW-1:0]     row_q, row_d;
  logic [TW-1:0]     col_q, col_d;
  logic [2*TW-1:0]   tdone_q, tdone_d;
  logic              err_q, err_d;
  logic [LCW-1:0]    ld_q, ld_d;

  logic wd_start, wd_clear, wd_exp;
  logic load_last, last_tile, last_col;

  ws_wdog #(.W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wd_start),
    .clear   (wd_clear),
    .limit   (WD_LIMIT),
    .expired (wd_exp)
  );

  assign load_last = (ld_q == LD_LAST);
  assign last_col  = (col_q == cols_q - IDX_ONE);
  assign last_tile = last_col && (row_q == rows_q - IDX_ONE);

  // Outputs are decoded from the state; abort/watchdog suppress pending pulses
  assign bus.cmd_ready         = (state_q == ST_IDLE);
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_FIN);
  assign bus.arr_start_load    = (state_q == ST_ISSUE) && !bus.abort;
  assign bus.arr_start_compute = (state_q == ST_LOADW) && load_last && !bus.abort && !wd_exp;
  assign bus.wb_valid          = (state_q == ST_WB) && !bus.abort;
  assign bus.tile_row          = row_q;
  assign bus.tile_col          = col_q;
  assign bus.tiles_done        = tdone_q;
  assign bus.err               = err_q;

  // Next-state and datapath update; abort overrides whatever the state chose
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    tdone_d  = tdone_q;
    err_d    = err_q;
    ld_d     = ld_q;
    wd_start = 1'b0;
    wd_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          rows_d  = bus.cmd_rows;
          cols_d  = bus.cmd_cols;
          row_d   = '0;
          col_d   = '0;
          tdone_d = '0;
          err_d   = 1'b0;
          state_d = (bus.cmd_rows == '0 || bus.cmd_cols == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_start = 1'b1;
        ld_d     = '0;
        state_d  = ST_LOADW;
      end
      ST_LOADW: begin
        if (wd_exp) begin
          err_d    = 1'b1;
          wd_clear = 1'b1;
          state_d  = ST_FIN;
        end else if (load_last) begin
          state_d  = ST_COMP;
        end else begin
          ld_d     = ld_q + LCW'(1);
        end
      end
      ST_COMP: begin
        // A tile finishing in the watchdog's last cycle still counts as on time
        if (bus.arr_done) begin
          wd_clear = 1'b1;
          state_d  = ST_WB;
        end else if (wd_exp) begin
          err_d    = 1'b1;
          wd_clear = 1'b1;
          state_d  = ST_FIN;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          tdone_d = tdone_q + CNT_ONE;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // The final tile leaves the indices pointing at itself
        if (last_tile) begin
          state_d = ST_FIN;
        end else if (last_col) begin
          col_d   = '0;
          row_d   = row_q + IDX_ONE;
          state_d = ST_ISSUE;
        end else begin
          col_d   = col_q + IDX_ONE;
          state_d = ST_ISSUE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort && state_q != ST_IDLE) begin
      err_d    = 1'b1;
      wd_clear = 1'b1;
      wd_start = 1'b0;
      tdone_d  = tdone_q;
      row_d    = row_q;
      col_d    = col_q;
      // FIN is already finishing; going back to FIN would repeat done
      state_d  = (state_q == ST_FIN) ? ST_IDLE : ST_FIN;
    end
  end

  // State and job registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tdone_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tdone_q <= tdone_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_ws_tile_sched.sv
// Directed bench for ws_tile_sched with M=N=4, K=128, WDOG_SLACK=8.
module tb_ws_tile_sched;

  localparam int TW   = 8;
  localparam int KLEN = 128;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ws_tile_sched_if #(.TW(TW)) bus ();

  ws_tile_sched #(
    .M(4), .N(4), .K(KLEN), .TW(TW), .WDOG_SLACK(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.arr_start_load;
      1:       return bus.arr_start_compute;
      2:       return bus.wb_valid;
      default: return bus.done;
    endcase
  endfunction

  task automatic wait_for(input int w, input int lim, input string tag, output int n);
    n = 0;
    while (sel(w) !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) chk(tag, {31'd0, sel(w)}, 32'd1);
  endtask

  task automatic send_cmd(input int r, input int c);
    bus.cmd_valid = 1'b1;
    bus.cmd_rows  = TW'(r);
    bus.cmd_cols  = TW'(c);
    tick();
    bus.cmd_valid = 1'b0;
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    $display("cmd rows=%0d cols=%0d accepted", r, c);
  endtask

  // Drive one tile from arr_start_load up to the first WB cycle
  task automatic to_wb(input int r, input int c);
    int n;
    wait_for(0, 400, "load_timeout", n);
    chk("tile_row", 32'(bus.tile_row), 32'(r));
    chk("tile_col", 32'(bus.tile_col), 32'(c));
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.arr_start_compute !== 1'b1 && n < 100);
    chk("load_to_compute", 32'(n), 32'd16);
    repeat (KLEN) tick();
    bus.arr_done = 1'b1;
    tick();
    bus.arr_done = 1'b0;
    chk("wb_valid_latency", {31'd0, bus.wb_valid}, 32'd1);
  endtask

  task automatic tile_flow(input int r, input int c, input int hold, input int exp_cnt);
    to_wb(r, c);
    if (hold > 0) begin
      bus.wb_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        chk("wb_hold_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("wb_hold_row", 32'(bus.tile_row), 32'(r));
        chk("wb_hold_col", 32'(bus.tile_col), 32'(c));
        chk("wb_hold_noload", {31'd0, bus.arr_start_load}, 32'd0);
        if (i == hold - 1) bus.wb_ready = 1'b1;
        tick();
      end
    end else begin
      tick();
    end
    chk("tiles_done", 32'(bus.tiles_done), 32'(exp_cnt));
    chk("wb_released", {31'd0, bus.wb_valid}, 32'd0);
    $display("tile (%0d,%0d) written back, tiles_done=%0d", r, c, bus.tiles_done);
  endtask

  task automatic finish_job(input int exp_tiles, input int exp_err);
    int n;
    wait_for(3, 400, "done_timeout", n);
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("final_tiles", 32'(bus.tiles_done), 32'(exp_tiles));
    chk("final_err", {31'd0, bus.err}, 32'(exp_err));
    tick();
    chk("done_single", {31'd0, bus.done}, 32'd0);
    chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    $display("job finished tiles=%0d err=%0d", exp_tiles, exp_err);
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_rows  = '0;
    bus.cmd_cols  = '0;
    bus.abort     = 1'b0;
    bus.arr_done  = 1'b0;
    bus.wb_ready  = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_wb", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_tiles", 32'(bus.tiles_done), 32'd0);
    rst_n = 1'b1;
    $display("reset state checked");

    // 2x3 job, row-major traversal
    send_cmd(2, 3);
    tile_flow(0, 0, 0, 1);
    tile_flow(0, 1, 0, 2);
    tile_flow(0, 2, 0, 3);
    tile_flow(1, 0, 0, 4);
    tile_flow(1, 1, 0, 5);
    tile_flow(1, 2, 0, 6);
    finish_job(6, 0);

    // Single tile with writeback stalled 5 cycles
    send_cmd(1, 1);
    tile_flow(0, 0, 5, 1);
    finish_job(1, 0);

    // Watchdog: arr_done never arrives
    send_cmd(1, 1);
    wait_for(0, 400, "wdog_load_timeout", n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 400);
    chk("wdog_cycles", 32'(n), 32'd152);
    chk("wdog_err", {31'd0, bus.err}, 32'd1);
    chk("wdog_tiles", 32'(bus.tiles_done), 32'd0);
    tick();
    chk("wdog_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("wdog_err_sticky", {31'd0, bus.err}, 32'd1);
    $display("watchdog fired after %0d cycles", n);

    // Abort during compute of tile 2 of 4
    send_cmd(2, 2);
    chk("err_cleared", {31'd0, bus.err}, 32'd0);
    tile_flow(0, 0, 0, 1);
    wait_for(1, 400, "abort_comp_timeout", n);
    repeat (10) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_done", {31'd0, bus.done}, 32'd1);
    chk("abort_err", {31'd0, bus.err}, 32'd1);
    chk("abort_tiles", 32'(bus.tiles_done), 32'd1);
    tick();
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    $display("abort in compute handled");

    // Zero-row job goes straight to FIN
    send_cmd(0, 3);
    chk("zero_done", {31'd0, bus.done}, 32'd1);
    chk("zero_noload", {31'd0, bus.arr_start_load}, 32'd0);
    chk("zero_tiles", 32'(bus.tiles_done), 32'd0);
    chk("zero_err", {31'd0, bus.err}, 32'd0);
    tick();
    chk("zero_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("zero_noload2", {31'd0, bus.arr_start_load}, 32'd0);
    $display("zero-row job handled");

    // Abort coincident with wb_ready in WB: tile not counted
    send_cmd(1, 1);
    to_wb(0, 0);
    bus.abort = 1'b1;
    #1;
    chk("abort_wb_drop", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    bus.abort = 1'b0;
    chk("abort_wb_done", {31'd0, bus.done}, 32'd1);
    chk("abort_wb_tiles", 32'(bus.tiles_done), 32'd0);
    chk("abort_wb_err", {31'd0, bus.err}, 32'd1);
    tick();
    $display("abort in writeback handled");

    // Reset during weight load
    send_cmd(1, 1);
    wait_for(0, 400, "rst_load_timeout", n);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("midrst_err", {31'd0, bus.err}, 32'd0);
    chk("midrst_tiles", 32'(bus.tiles_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_nodone", {31'd0, bus.done}, 32'd0);
    end
    rst_n = 1'b1;
    send_cmd(1, 2);
    tile_flow(0, 0, 0, 1);
    tile_flow(0, 1, 0, 2);
    finish_job(2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
